// File: rtl/teclado_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package teclado_pkg;

    localparam int N_COL = 4;
    localparam int N_FIL = 4;
    localparam logic [N_COL-1:0] COL_RST = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        WAIT_REL,
        REL_DEB
    } estado_t;

    // Lowest-index active-low row; row 0 has the highest priority.
    function automatic logic [1:0] fila_baja(input logic [N_FIL-1:0] filas);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N_FIL - 1; i >= 0; i--) begin
            if (!filas[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [N_COL-1:0] col_drive(input logic [1:0] idx);
        return ~(~COL_RST << idx);
    endfunction

endpackage

// File: rtl/module_sincronizador.sv
// Purpose: 2-FF synchroniser for asynchronous level inputs, idles high.
// Latency: 2 clk cycles.
// Backpressure: none, free-running.
module module_sincronizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/module_barrido_teclado.sv
// Purpose: scan a 4x4 active-low keypad, debounce press/release, emit one code pulse per key.
// Latency: pulse T_DEB+1 cycles after the first low row sample (plus 2 sync cycles).
// Backpressure: none; the decoder must accept each single-cycle dato_listo_o pulse.
module module_barrido_teclado
    import teclado_pkg::*;
#(
    parameter int T_COL = 27000,
    parameter int T_DEB = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_FIL-1:0] filas_i,
    output logic [N_COL-1:0] columnas_o,
    output logic             dato_listo_o,
    output logic [1:0]       dato_codc_o,
    output logic [1:0]       dato_codf_o
);

    localparam int CNT_MAX = (T_COL > T_DEB) ? T_COL : T_DEB;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(T_COL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(T_DEB - 1);

    logic [N_FIL-1:0] filas_s;

    estado_t          state_d, state_q;
    logic [1:0]       col_d, col_q;
    logic [1:0]       fila_d, fila_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             listo_d, listo_q;
    logic [1:0]       codc_d, codc_q;
    logic [1:0]       codf_d, codf_q;

    module_sincronizador #(
        .W (N_FIL)
    ) u_sinc_filas (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (filas_i),
        .q_o   (filas_s)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        fila_d  = fila_q;
        cnt_d   = cnt_q + 1'b1;
        listo_d = 1'b0;
        codc_d  = codc_q;
        codf_d  = codf_q;
        case (state_q)
            SCAN: begin
                // Rows are only trusted on the last dwell cycle, after the lines settle.
                if (cnt_q == COL_LAST) begin
                    cnt_d = '0;
                    if (!(&filas_s)) begin
                        fila_d  = fila_baja(filas_s);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (filas_s[fila_q]) begin
                    cnt_d   = '0;
                    col_d   = col_q + 1'b1;
                    state_d = SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    listo_d = 1'b1;
                    codc_d  = col_q;
                    codf_d  = fila_q;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                cnt_d = '0;
                if (&filas_s) state_d = REL_DEB;
            end
            REL_DEB: begin
                if (!(&filas_s)) begin
                    cnt_d   = '0;
                    state_d = WAIT_REL;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    col_d   = col_q + 1'b1;
                    state_d = SCAN;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            fila_q  <= 2'd0;
            cnt_q   <= '0;
            listo_q <= 1'b0;
            codc_q  <= 2'd0;
            codf_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            fila_q  <= fila_d;
            cnt_q   <= cnt_d;
            listo_q <= listo_d;
            codc_q  <= codc_d;
            codf_q  <= codf_d;
        end
    end

    assign columnas_o   = col_drive(col_q);
    assign dato_listo_o = listo_q;
    assign dato_codc_o  = codc_q;
    assign dato_codf_o  = codf_q;

endmodule

// File: tb/tb_module_barrido_teclado.sv
// Bench for the keypad scanner: a matrix model closes keys, a scoreboard matches code pulses.
module tb_module_barrido_teclado;

    localparam int T_COL = 4;
    localparam int T_DEB = 8;
    // Release-to-next-column: 2 sync stages + 1 WAIT_REL detect + T_DEB stable cycles.
    localparam int REL_LAT = 2 + 1 + T_DEB;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] filas_i;
    logic [3:0] columnas_o;
    logic       dato_listo_o;
    logic [1:0] dato_codc_o;
    logic [1:0] dato_codf_o;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    logic [3:0]  seq [4];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pulse  = 0;
    int          n_double = 0;
    logic        prev_listo = 1'b0;
    int          n;
    int          k;
    bit          ok;

    always #5 clk = ~clk;

    module_barrido_teclado #(
        .T_COL (T_COL),
        .T_DEB (T_DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filas_i      (filas_i),
        .columnas_o   (columnas_o),
        .dato_listo_o (dato_listo_o),
        .dato_codc_o  (dato_codc_o),
        .dato_codf_o  (dato_codf_o)
    );

    // Key index = col*4 + row; a closed key pulls its row low while its column is driven.
    always_comb begin
        filas_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!columnas_o[c] && keys[c*4+r]) filas_i[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && dato_listo_o) begin
            got_q.push_back({dato_codc_o, dato_codf_o});
            n_pulse++;
            if (prev_listo) n_double++;
        end
        prev_listo = dato_listo_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drain_sb(input string tag);
        check_eq({tag, "_npulse"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, "_code"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_col_change(output int cycles);
        logic [3:0] c0;
        c0 = columnas_o;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (columnas_o == c0 && cycles < 60);
    endtask

    task automatic wait_pulse(output bit seen);
        int t;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 60) begin
            @(negedge clk);
            t++;
            if (dato_listo_o) seen = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        seq[0] = 4'b1011;
        seq[1] = 4'b0111;
        seq[2] = 4'b1110;
        seq[3] = 4'b1101;
        keys = '0;
        rst  = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_col", columnas_o, 4'b1110);
        check_eq("rst_listo", dato_listo_o, 1'b0);
        check_eq("rst_codc", dato_codc_o, 2'd0);
        check_eq("rst_codf", dato_codf_o, 2'd0);
        #20 rst = 1'b1;

        // 1: idle scan sequence and dwell
        wait_col_change(n);
        check_eq("t1_first_col", columnas_o, 4'b1101);
        for (int i = 0; i < 4; i++) begin
            wait_col_change(n);
            check_eq("t1_dwell", n, T_COL);
            check_eq("t1_col", columnas_o, seq[i]);
        end

        // 2: col1/row1 held for ~200 cycles
        keys[5] = 1'b1;
        exp_q.push_back(4'b0101);
        wait_pulse(ok);
        check_eq("t2_pulse_seen", ok, 1'b1);
        repeat (180) @(negedge clk);
        check_eq("t2_hold_col", columnas_o, 4'b1101);
        keys[5] = 1'b0;
        wait_col_change(n);
        check_eq("t2_rel_lat", n, REL_LAT);
        check_eq("t2_next_col", columnas_o, 4'b1011);
        drain_sb("t2");

        // 3: 3-cycle bounce on col2/row0
        keys[8] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 3) keys[8] = 1'b0;
        end while (columnas_o == 4'b1011 && k < 40);
        check_eq("t3_dwell", k, 6);
        check_eq("t3_next_col", columnas_o, 4'b0111);
        check_eq("t3_codc", dato_codc_o, 2'd1);
        check_eq("t3_codf", dato_codf_o, 2'd1);
        drain_sb("t3");

        // 4: accepted col3/row2, bouncy release
        keys[14] = 1'b1;
        exp_q.push_back(4'b1110);
        wait_pulse(ok);
        check_eq("t4_pulse_seen", ok, 1'b1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            keys[14] = 1'b0;
            repeat (2) @(negedge clk);
            keys[14] = 1'b1;
            repeat (2) @(negedge clk);
        end
        check_eq("t4_held_col", columnas_o, 4'b0111);
        keys[14] = 1'b0;
        wait_col_change(n);
        check_eq("t4_rel_lat", n, REL_LAT);
        check_eq("t4_next_col", columnas_o, 4'b1110);
        drain_sb("t4");

        // 5: col0 rows 0 and 2 together, release row0 only
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        exp_q.push_back(4'b0000);
        wait_pulse(ok);
        check_eq("t5_pulse_seen", ok, 1'b1);
        repeat (4) @(negedge clk);
        keys[0] = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("t5_held_col", columnas_o, 4'b1110);
        keys[2] = 1'b0;
        wait_col_change(n);
        check_eq("t5_rel_lat", n, REL_LAT);
        check_eq("t5_next_col", columnas_o, 4'b1101);
        drain_sb("t5");

        // 6: reset at debounce count 5 on col3/row3
        keys[15] = 1'b1;
        wait_col_change(n);
        wait_col_change(n);
        check_eq("t6_col3", columnas_o, 4'b0111);
        repeat (4 + 5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_rst_col", columnas_o, 4'b1110);
        check_eq("t6_rst_listo", dato_listo_o, 1'b0);
        check_eq("t6_rst_codc", dato_codc_o, 2'd0);
        check_eq("t6_rst_codf", dato_codf_o, 2'd0);
        keys = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        wait_col_change(n);
        check_eq("t6_restart_dwell", n, T_COL);
        check_eq("t6_restart_col", columnas_o, 4'b1101);
        drain_sb("t6");

        check_eq("double_pulse", n_double, 0);
        check_eq("total_pulses", n_pulse, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
